xgmii_pcs_tx_enc: RTL
=====================

# xgmii_pcs_tx_enc

Parametrised XGMII transmit encoder for the 10G PCS. Accepts 32-bit or 64-bit XGMII transmit data and gathers it into 64-bit blocks. Classifies each block, runs the Clause 49 transmit state machine and emits 66-bit encoded blocks (sync header, block type, payload) toward the gearbox. It also supports an optional self-synchronous scrambler.

## Interface
- `XGMII_DATA_W`, default 64: XGMII data width; legal values are 32 and 64.
- `XGMII_CTRL_W`, default `XGMII_DATA_W/8`: control width, derived; do not override.
- `clk`  in  1  PCS transmit clock.
- `reset`  in  1  asynchronous, active-high reset.
- `xgmii_txd_i`  in  XGMII_DATA_W  transmit data; byte lane n is at bits [8n+7:8n].
- `xgmii_txc_i`  in  XGMII_CTRL_W  per-lane control flag; 1 means the lane holds a control character.
- `data_o`  out  66  encoded block; [1:0] sync header, [65:2] block body.
- `valid_o`  out  1  `data_o` holds a new block this cycle.
- `err_cnt_o`  out  16  count of error blocks emitted; saturates at 16'hFFFF.

## Operation
- **XGMII characters:** idle 0x07, start 0xFB, terminate 0xFD, error 0xFE.
- **Block assembly, 64-bit mode:** one block per cycle.
- **Block assembly, 32-bit mode:**
  - A phase bit, reset to 0, toggles every cycle.
  - Phase 0 captures lanes 0–3 into a holding register.
  - Phase 1 supplies lanes 4–7, and the block is complete.
- **Classification of each 64-bit block:**
  - D: all 8 lanes are data.
  - S: start in lane 0 with data in lanes 1–7, or idles in lanes 0–3, start in lane 4 and data in lanes 5–7.
  - T: terminate in lane k (k = 0..7), data in lanes 0..k-1 and idles in lanes k+1..7.
  - C: every lane is idle or error.
  - E: anything else.
- **Encoding:**
  - D blocks: sync 2'b01, payload is the 64 data bits.
  - All other blocks: sync 2'b10, type byte at [9:2].
  - Control codes are 7 bits: idle 0x00, error 0x1E.
  - C: type 0x1E followed by eight 7-bit codes.
  - S in lane 0: type 0x78 followed by D1–D7.
  - S in lane 4: type 0x33, codes C0–C3, 4'b0, then D5–D7.
  - T_k type bytes for k = 0..7: 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF. D0..D(k-1) are followed by zero pad, then 7-bit idle codes for lanes k+1..7, laid out per Clause 49.
- **TX FSM states:** INIT (reset state), C, D, T, E.
  - From INIT or C: C→C, S→D, else →E.
  - From D: D→D, T→T, else →E.
  - From T: C→C, S→D, else →E.
  - From E: C→C, S→D, D→D, T→T, else →E.
  - Entering E emits an error block (type 0x1E, eight 0x1E codes) in place of the input block.
  - Each error block increments `err_cnt_o`, which saturates at 16'hFFFF.
- In 32-bit mode the FSM advances only on complete blocks (phase 1).

## Timing
- **Reset values:** `data_o` = 66'h0, `valid_o` = 0, `err_cnt_o` = 0, FSM = INIT, phase = 0. In 32-bit mode the holding register clears on reset.
- **64-bit mode:** latency is 1 cycle from input to registered `data_o`; `valid_o` is constantly 1 after reset deasserts.
- **32-bit mode:** the block appears on the cycle after phase 1. `valid_o` pulses every second cycle; `data_o` holds its value between pulses.
- **Reset mid-block:** a partial block in the holding register is discarded, and the phase restarts at 0.
- **Error blocks:** no extra latency; the substitution happens in the same cycle.

## Configuration
- **`PCS_TX_SCRAMBLER_EN` defined:**
  - Bits [65:2] are scrambled with the self-synchronous polynomial x^58 + x^39 + 1, bit 2 first; the sync header is never scrambled.
  - The 58-bit state resets to all ones.
  - The state advances only on blocks where `valid_o` is asserted; no added latency.
- **Undefined:** bits [65:2] are emitted unscrambled.

## Test plan
- **Idles (64-bit mode):** txc = 8'hFF, txd = all 0x07 → `data_o[1:0]` = 2'b10, [9:2] = 8'h1E, [65:10] = 0; `err_cnt_o` = 0.
- **Frame:** start 0xFB in lane 0 with data 01..07, then a D block 0x1122334455667788, then T_3 with data AA BB CC → types 0x78, then sync 2'b01 with payload passed through, then 0xB4; FSM sequence C→D→D→T.
- **Illegal start:** a start block arrives while in state D → error block emitted (type 0x1E, codes 0x1E) and `err_cnt_o` = 1. A following C block returns the FSM to C.
- **32-bit mode:** lanes 0–3 = FB,01,02,03, then lanes 4–7 = 04,05,06,07 → one block of type 0x78; `valid_o` high every second cycle only.
- **Reset during 32-bit phase 1:** reset asserts after phase 0 → no block is emitted and the next block assembles from fresh lanes 0–3.
- **With `PCS_TX_SCRAMBLER_EN`:** idle stream → first payload equals the idle payload scrambled from the all-ones seed, matching the reference-model vectors; sync header is unchanged.

Source files
------------

// File: rtl/xgmii_pcs_tx_enc.sv
// XGMII (32/64-bit) to 64b/66b transmit encoder with the 10GBASE-R transmit state machine.
// Define PCS_TX_SCRAMBLER_EN to scramble the block body with x^58 + x^39 + 1.
module xgmii_pcs_tx_enc #(
  parameter int XGMII_DATA_W = 64,
  parameter int XGMII_CTRL_W = XGMII_DATA_W/8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [XGMII_DATA_W-1:0] xgmii_txd_i,
  input  logic [XGMII_CTRL_W-1:0] xgmii_txc_i,
  output logic [65:0]             data_o,
  output logic                    valid_o,
  output logic [15:0]             err_cnt_o
);

  localparam logic [7:0]  CH_IDLE  = 8'h07;
  localparam logic [7:0]  CH_START = 8'hFB;
  localparam logic [7:0]  CH_TERM  = 8'hFD;
  localparam logic [7:0]  CH_ERR   = 8'hFE;
  localparam logic [6:0]  CC_IDLE  = 7'h00;
  localparam logic [6:0]  CC_ERR   = 7'h1E;
  localparam logic [63:0] ERR_BODY = {{8{CC_ERR}}, 8'h1E};

  typedef enum logic [2:0] {ST_INIT, ST_C, ST_D, ST_T, ST_E} state_t;
  typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_t;

  logic [63:0] blk_d;
  logic [7:0]  blk_c;
  logic        blk_done;

  generate
    if (XGMII_DATA_W == 64) begin : g_w64
      assign blk_d    = xgmii_txd_i[63:0];
      assign blk_c    = xgmii_txc_i[7:0];
      assign blk_done = 1'b1;
    end else begin : g_w32
      logic        phase_reg;
      logic [31:0] hold_d_reg;
      logic [3:0]  hold_c_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          phase_reg  <= 1'b0;
          hold_d_reg <= '0;
          hold_c_reg <= '0;
        end else begin
          phase_reg <= ~phase_reg;
          if (!phase_reg) begin
            hold_d_reg <= xgmii_txd_i[31:0];
            hold_c_reg <= xgmii_txc_i[3:0];
          end
        end
      end

      assign blk_d    = {xgmii_txd_i[31:0], hold_d_reg};
      assign blk_c    = {xgmii_txc_i[3:0], hold_c_reg};
      assign blk_done = phase_reg;
    end
  endgenerate

  logic [7:0] ln_data, ln_idle, ln_err, ln_start, ln_term, t_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      // Terminate in lane gi needs data below it and idles above it.
      localparam logic [7:0] LO_MASK = 8'((1 << gi) - 1);
      localparam logic [7:0] HI_MASK = 8'(~((2 << gi) - 1));
      logic [7:0] ch;
      assign ch           = blk_d[8*gi +: 8];
      assign ln_data[gi]  = ~blk_c[gi];
      assign ln_idle[gi]  = blk_c[gi] & (ch == CH_IDLE);
      assign ln_err[gi]   = blk_c[gi] & (ch == CH_ERR);
      assign ln_start[gi] = blk_c[gi] & (ch == CH_START);
      assign ln_term[gi]  = blk_c[gi] & (ch == CH_TERM);
      assign t_ok[gi]     = ln_term[gi] & ((ln_data & LO_MASK) == LO_MASK)
                                        & ((ln_idle & HI_MASK) == HI_MASK);
    end
  endgenerate

  blk_t       blk_class;
  logic [2:0] term_lane;

  always_comb begin
    blk_class = BLK_E;
    term_lane = 3'd0;
    if (&ln_data) begin
      blk_class = BLK_D;
    end else if ((ln_start[0] && (&ln_data[7:1])) ||
                 ((&ln_idle[3:0]) && ln_start[4] && (&ln_data[7:5]))) begin
      blk_class = BLK_S;
    end else if (&(ln_idle | ln_err)) begin
      blk_class = BLK_C;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (t_ok[k]) begin
          blk_class = BLK_T;
          term_lane = 3'(k);
        end
      end
    end
  end

  state_t state_reg, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         state_reg <= ST_INIT;
    else if (blk_done) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT, ST_C, ST_T:
        state_next = (blk_class == BLK_C) ? ST_C :
                     (blk_class == BLK_S) ? ST_D : ST_E;
      ST_D:
        state_next = (blk_class == BLK_D) ? ST_D :
                     (blk_class == BLK_T) ? ST_T : ST_E;
      default:
        case (blk_class)
          BLK_C:        state_next = ST_C;
          BLK_S, BLK_D: state_next = ST_D;
          BLK_T:        state_next = ST_T;
          default:      state_next = ST_E;
        endcase
    endcase
  end

  logic [1:0]  enc_sync;
  logic [63:0] enc_body;
  logic [7:0]  t_type;
  logic        enc_err;

  always_comb begin
    case (term_lane)
      3'd0:    t_type = 8'h87;
      3'd1:    t_type = 8'h99;
      3'd2:    t_type = 8'hAA;
      3'd3:    t_type = 8'hB4;
      3'd4:    t_type = 8'hCC;
      3'd5:    t_type = 8'hD2;
      3'd6:    t_type = 8'hE1;
      default: t_type = 8'hFF;
    endcase
  end

  always_comb begin
    enc_sync = 2'b10;
    enc_body = ERR_BODY;
    case (blk_class)
      BLK_D: begin
        enc_sync = 2'b01;
        enc_body = blk_d;
      end
      BLK_S: enc_body = ln_start[0] ? {blk_d[63:8], 8'h78} : {blk_d[63:40], 32'h0, 8'h33};
      BLK_T: begin
        // Idle codes are zero, so the trailing control fields collapse into the pad.
        enc_body = {56'h0, t_type};
        for (int j = 0; j < 7; j++)
          if (j < int'(term_lane)) enc_body[8+8*j +: 8] = blk_d[8*j +: 8];
      end
      BLK_C: begin
        enc_body = {56'h0, 8'h1E};
        for (int i = 0; i < 8; i++)
          enc_body[8+7*i +: 7] = ln_err[i] ? CC_ERR : CC_IDLE;
      end
      default: ;
    endcase
    enc_err = (state_next == ST_E);
    if (enc_err) begin
      enc_sync = 2'b10;
      enc_body = ERR_BODY;
    end
  end

  logic [63:0] tx_body;

`ifdef PCS_TX_SCRAMBLER_EN
  logic [57:0] scr_reg, scr_next;

  // scr_next[0] is always the most recently scrambled bit.
  always_comb begin
    scr_next = scr_reg;
    tx_body  = enc_body;
    for (int i = 0; i < 64; i++) begin
      tx_body[i] = enc_body[i] ^ scr_next[38] ^ scr_next[57];
      scr_next   = {scr_next[56:0], tx_body[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         scr_reg <= '1;
    else if (blk_done) scr_reg <= scr_next;
  end
`else
  assign tx_body = enc_body;
`endif

  logic [65:0] data_reg;
  logic        valid_reg;
  logic [15:0] err_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      valid_reg <= blk_done;
      if (blk_done) begin
        data_reg <= {tx_body, enc_sync};
        if (enc_err && (err_cnt_reg != 16'hFFFF)) err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

  assign data_o    = data_reg;
  assign valid_o   = valid_reg;
  assign err_cnt_o = err_cnt_reg;

endmodule
